// File: rtl/mips_mem_arbiter_if.sv
// Requester, memory and debug-visibility signals of the MIPS memory arbiter.
// slave = arbiter side, master = requesters/memory/observer side.
interface mips_mem_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;

   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_rvalid;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic          dbg_rvalid;

   logic [DW-1:0] rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic          busy;
   logic [3:0]    starve_cnt;
   // FSM state: 0 IDLE, 1 GRANT, 2 WAIT, 3 RESP
   logic [1:0]    arb_state;

   // Handshake: a requester holds req and its fields until it sees its
   // one-cycle gnt; read data comes back on rdata with a one-cycle rvalid.
   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid,
      output rdata, mem_en, mem_we, mem_addr, mem_wdata,
      output busy, starve_cnt, arb_state
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid,
      input  rdata, mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, starve_cnt, arb_state
   );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for IF / DM / DBG over a fixed-latency memory.
// Priority DBG > DM > IF, with IF force-granted after STARVE_LIMIT losses.
module mips_mem_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset_n,
   mips_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

   localparam logic [1:0] ID_IF  = 2'd0;
   localparam logic [1:0] ID_DM  = 2'd1;
   localparam logic [1:0] ID_DBG = 2'd2;
   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_e        state_q;
   logic [1:0]    id_q;
   logic          we_q;
   logic [2:0]    lat_q;
   logic [3:0]    starve_q;
   logic          if_gnt_q, dm_gnt_q, dbg_gnt_q;
   logic          if_rv_q, dm_rv_q, dbg_rv_q;
   logic          mem_en_q, mem_we_q, busy_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q, rdata_q;

   logic          any_req, force_if;
   logic [1:0]    win_d;
   logic          win_we_d;
   logic [AW-1:0] win_addr_d;
   logic [DW-1:0] win_wdata_d;
   logic [3:0]    starve_d;

   // Winner and starvation update, consumed only at IDLE/RESP edges.
   always_comb begin
      any_req     = bus.if_req | bus.dm_req | bus.dbg_req;
      force_if    = bus.if_req && (starve_q == STARVE_MAX);
      win_d       = ID_IF;
      win_we_d    = 1'b0;
      win_addr_d  = bus.if_addr;
      win_wdata_d = '0;
      if (!force_if && bus.dbg_req) begin
         win_d       = ID_DBG;
         win_we_d    = bus.dbg_we;
         win_addr_d  = bus.dbg_addr;
         win_wdata_d = bus.dbg_wdata;
      end else if (!force_if && bus.dm_req) begin
         win_d       = ID_DM;
         win_we_d    = bus.dm_we;
         win_addr_d  = bus.dm_addr;
         win_wdata_d = bus.dm_wdata;
      end
      starve_d = starve_q;
      if (!bus.if_req || win_d == ID_IF) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         id_q        <= ID_IF;
         we_q        <= 1'b0;
         lat_q       <= '0;
         starve_q    <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         dbg_gnt_q   <= 1'b0;
         if_rv_q     <= 1'b0;
         dm_rv_q     <= 1'b0;
         dbg_rv_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         if_gnt_q  <= 1'b0;
         dm_gnt_q  <= 1'b0;
         dbg_gnt_q <= 1'b0;
         if_rv_q   <= 1'b0;
         dm_rv_q   <= 1'b0;
         dbg_rv_q  <= 1'b0;
         mem_en_q  <= 1'b0;
         mem_we_q  <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               starve_q <= starve_d;
               if (any_req) begin
                  state_q     <= GRANT;
                  busy_q      <= 1'b1;
                  id_q        <= win_d;
                  we_q        <= win_we_d;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= win_we_d;
                  mem_addr_q  <= win_addr_d;
                  mem_wdata_q <= win_wdata_d;
                  if_gnt_q    <= (win_d == ID_IF);
                  dm_gnt_q    <= (win_d == ID_DM);
                  dbg_gnt_q   <= (win_d == ID_DBG);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            GRANT: begin
               state_q <= WAIT;
               lat_q   <= LAT_INIT;
            end
            WAIT: begin
               if (lat_q == 3'd1) begin
                  state_q <= RESP;
                  lat_q   <= '0;
                  // Writes leave rdata untouched and return no pulse.
                  if (!we_q) begin
                     rdata_q  <= bus.mem_rdata;
                     if_rv_q  <= (id_q == ID_IF);
                     dm_rv_q  <= (id_q == ID_DM);
                     dbg_rv_q <= (id_q == ID_DBG);
                  end
               end else begin
                  lat_q <= lat_q - 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.if_gnt     = if_gnt_q;
   assign bus.dm_gnt     = dm_gnt_q;
   assign bus.dbg_gnt    = dbg_gnt_q;
   assign bus.if_rvalid  = if_rv_q;
   assign bus.dm_rvalid  = dm_rv_q;
   assign bus.dbg_rvalid = dbg_rv_q;
   assign bus.rdata      = rdata_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.busy       = busy_q;
   assign bus.starve_cnt = starve_q;
   assign bus.arb_state  = state_q;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter with MEM_LAT = 3, STARVE_LIMIT = 4: cycle table
// plus starvation, withdrawn-request and mid-access reset sequences.
module tb_mips_mem_arbiter;
   localparam int LAT = 3;
   localparam logic [9:0] A_IF  = 10'h005;
   localparam logic [9:0] A_DM  = 10'h3FF;
   localparam logic [9:0] A_DBG = 10'h010;

   logic clk;
   logic reset_n;
   int   cyc;
   int   checks;
   int   errors;

   mips_mem_arbiter_if #(.AW(10), .DW(32)) bus ();

   mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(LAT), .STARVE_LIMIT(4)) dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read data is valid only in the single cycle LAT cycles
   // after the mem_en cycle, junk otherwise.
   logic [31:0] mem_model [1024];
   logic [2:0]  rd_cnt;
   logic [31:0] rd_data;
   always @(posedge clk) begin
      if (!reset_n) begin
         mem_model[A_IF]  <= 32'h2001_0003;
         mem_model[A_DM]  <= 32'h0000_3FF0;
         mem_model[A_DBG] <= 32'h1234_5678;
         rd_cnt           <= '0;
         rd_data          <= '0;
      end else begin
         if (rd_cnt != 0) rd_cnt <= rd_cnt - 3'd1;
         if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
            else begin
               rd_cnt  <= 3'(LAT);
               rd_data <= mem_model[bus.mem_addr];
            end
         end
      end
   end
   assign bus.mem_rdata = (rd_cnt == 3'd1) ? rd_data : 32'hBADB_AD00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ins = {if_req, dm_req, dm_we, dbg_req, dbg_we}; gnt/rv = {dbg, dm, if}
   typedef struct {
      logic [4:0]  ins;
      logic [2:0]  gnt;
      logic [2:0]  rv;
      logic        en;
      logic        we;
      logic [9:0]  addr;
      logic        busy;
      logic [3:0]  st;
      logic [31:0] rd;
   } vec_t;
   vec_t vq[$];

   function automatic void add(input logic [4:0] ins, input logic [2:0] g, input logic [2:0] rv,
                               input logic en, input logic we, input logic [9:0] a,
                               input logic bz, input logic [3:0] st, input logic [31:0] rd);
      vec_t v;
      v.ins = ins; v.gnt = g; v.rv = rv; v.en = en; v.we = we;
      v.addr = a; v.busy = bz; v.st = st; v.rd = rd;
      vq.push_back(v);
   endfunction

   function automatic logic [2:0] gnts();
      return {bus.dbg_gnt, bus.dm_gnt, bus.if_gnt};
   endfunction

   function automatic logic [2:0] rvs();
      return {bus.dbg_rvalid, bus.dm_rvalid, bus.if_rvalid};
   endfunction

   task automatic wait_gnt(input string name, output logic [2:0] g, output int at);
      g  = '0;
      at = -1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (gnts() != 3'b000) begin
            g  = gnts();
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no grant within 12 cycles", name);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, bus.busy}, 32'd0);
   endtask

   localparam logic [4:0] I_ALL  = 5'b11010;
   localparam logic [4:0] I_IFDM = 5'b11000;
   localparam logic [4:0] I_IF   = 5'b10000;
   localparam logic [4:0] I_NONE = 5'b00000;
   localparam logic [4:0] I_DMST = 5'b01100;
   localparam logic [4:0] I_DMLD = 5'b01000;

   initial begin
      logic [2:0] g;
      int         at;
      int         prev;
      int         cnt_a;
      int         cnt_b;
      logic [2:0] exp_g [6];
      logic [3:0] exp_s [6];

      checks = 0;
      errors = 0;
      cyc    = 0;
      reset_n       = 1'b0;
      bus.if_req    = 1'b0; bus.if_addr  = A_IF;
      bus.dm_req    = 1'b0; bus.dm_we    = 1'b0; bus.dm_addr  = A_DM;  bus.dm_wdata  = 32'hDEAD_BEEF;
      bus.dbg_req   = 1'b0; bus.dbg_we   = 1'b0; bus.dbg_addr = A_DBG; bus.dbg_wdata = 32'hCAFE_0001;

      repeat (3) @(negedge clk);
      check("rst_gnt",    {29'd0, gnts()}, 32'd0);
      check("rst_rvalid", {29'd0, rvs()}, 32'd0);
      check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      check("rst_busy",   {31'd0, bus.busy}, 32'd0);
      check("rst_starve", {28'd0, bus.starve_cnt}, 32'd0);
      check("rst_rdata",  bus.rdata, 32'd0);
      check("rst_state",  {30'd0, bus.arb_state}, 32'd0);
      reset_n = 1'b1;

      // All three together (DBG read, DM load, IF read), then DM store + load.
      add(I_ALL,  3'b000, 3'b000, 0, 0, 10'h000, 0, 0, 32'h0);
      add(I_IFDM, 3'b100, 3'b000, 1, 0, A_DBG,   1, 1, 32'h0);
      add(I_IFDM, 3'b000, 3'b000, 0, 0, A_DBG,   1, 1, 32'h0);
      add(I_IFDM, 3'b000, 3'b000, 0, 0, A_DBG,   1, 1, 32'h0);
      add(I_IFDM, 3'b000, 3'b000, 0, 0, A_DBG,   1, 1, 32'h0);
      add(I_IFDM, 3'b000, 3'b100, 0, 0, A_DBG,   1, 1, 32'h1234_5678);
      add(I_IF,   3'b010, 3'b000, 1, 0, A_DM,    1, 2, 32'h1234_5678);
      for (int i = 0; i < 3; i++)
         add(I_IF, 3'b000, 3'b000, 0, 0, A_DM,   1, 2, 32'h1234_5678);
      add(I_IF,   3'b000, 3'b010, 0, 0, A_DM,    1, 2, 32'h0000_3FF0);
      add(I_NONE, 3'b001, 3'b000, 1, 0, A_IF,    1, 0, 32'h0000_3FF0);
      for (int i = 0; i < 3; i++)
         add(I_NONE, 3'b000, 3'b000, 0, 0, A_IF, 1, 0, 32'h0000_3FF0);
      add(I_NONE, 3'b000, 3'b001, 0, 0, A_IF,    1, 0, 32'h2001_0003);
      add(I_DMST, 3'b000, 3'b000, 0, 0, A_IF,    0, 0, 32'h2001_0003);
      add(I_DMLD, 3'b010, 3'b000, 1, 1, A_DM,    1, 0, 32'h2001_0003);
      for (int i = 0; i < 4; i++)
         add(I_DMLD, 3'b000, 3'b000, 0, 0, A_DM, 1, 0, 32'h2001_0003);
      add(I_NONE, 3'b010, 3'b000, 1, 0, A_DM,    1, 0, 32'h2001_0003);
      for (int i = 0; i < 3; i++)
         add(I_NONE, 3'b000, 3'b000, 0, 0, A_DM, 1, 0, 32'h2001_0003);
      add(I_NONE, 3'b000, 3'b010, 0, 0, A_DM,    1, 0, 32'hDEAD_BEEF);
      add(I_NONE, 3'b000, 3'b000, 0, 0, A_DM,    0, 0, 32'hDEAD_BEEF);

      foreach (vq[i]) begin
         @(posedge clk);
         #1;
         {bus.if_req, bus.dm_req, bus.dm_we, bus.dbg_req, bus.dbg_we} = vq[i].ins;
         @(negedge clk);
         check($sformatf("row%0d gnt", i),    {29'd0, gnts()}, {29'd0, vq[i].gnt});
         check($sformatf("row%0d rvalid", i), {29'd0, rvs()}, {29'd0, vq[i].rv});
         check($sformatf("row%0d mem_en", i), {31'd0, bus.mem_en}, {31'd0, vq[i].en});
         check($sformatf("row%0d mem_we", i), {31'd0, bus.mem_we}, {31'd0, vq[i].we});
         check($sformatf("row%0d addr", i),   {22'd0, bus.mem_addr}, {22'd0, vq[i].addr});
         check($sformatf("row%0d busy", i),   {31'd0, bus.busy}, {31'd0, vq[i].busy});
         check($sformatf("row%0d starve", i), {28'd0, bus.starve_cnt}, {28'd0, vq[i].st});
         check($sformatf("row%0d rdata", i),  bus.rdata, vq[i].rd);
         if (vq[i].we) check($sformatf("row%0d wdata", i), bus.mem_wdata, 32'hDEAD_BEEF);
      end

      // Starvation: IF and DM loads held continuously.
      exp_g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
      exp_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
      @(posedge clk);
      #1;
      bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b0;
      prev = -1;
      for (int k = 0; k < 6; k++) begin
         wait_gnt($sformatf("starve%0d", k), g, at);
         check($sformatf("starve%0d gnt", k), {29'd0, g}, {29'd0, exp_g[k]});
         check($sformatf("starve%0d cnt", k), {28'd0, bus.starve_cnt}, {28'd0, exp_s[k]});
         if (k > 0) check($sformatf("starve%0d spacing", k), 32'(at - prev), 32'(LAT + 2));
         prev = at;
      end
      @(posedge clk);
      #1;
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      wait_idle("starve_idle");
      check("starve_cleared", {28'd0, bus.starve_cnt}, 32'd0);

      // Withdrawn IF request while a DBG write owns the memory.
      @(posedge clk);
      #1;
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.if_req = 1'b1;
      wait_gnt("wd_gnt", g, at);
      check("wd_dbg_gnt", {29'd0, g}, 32'b100);
      check("wd_starve1", {28'd0, bus.starve_cnt}, 32'd1);
      @(posedge clk);
      #1;
      bus.dbg_req = 1'b0; bus.if_req = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         cnt_a += int'(bus.if_gnt);
         cnt_b += int'(|rvs());
      end
      check("wd_no_if_gnt", 32'(cnt_a), 32'd0);
      check("wd_no_rvalid", 32'(cnt_b), 32'd0);
      check("wd_idle",      {31'd0, bus.busy}, 32'd0);
      check("wd_starve0",   {28'd0, bus.starve_cnt}, 32'd0);
      check("wd_mem_write", mem_model[A_DBG], 32'hCAFE_0001);

      // Reset in the middle of a DM load.
      @(posedge clk);
      #1;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = A_DBG;
      wait_gnt("rm_gnt", g, at);
      check("rm_dm_gnt", {29'd0, g}, 32'b010);
      @(posedge clk);
      #1;
      bus.dm_req = 1'b0;
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("rm_gnt0",    {29'd0, gnts()}, 32'd0);
      check("rm_rvalid0", {29'd0, rvs()}, 32'd0);
      check("rm_mem_en",  {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
      check("rm_addr",    {22'd0, bus.mem_addr}, 32'd0);
      check("rm_wdata",   bus.mem_wdata, 32'd0);
      check("rm_rdata",   bus.rdata, 32'd0);
      check("rm_busy",    {31'd0, bus.busy}, 32'd0);
      check("rm_starve",  {28'd0, bus.starve_cnt}, 32'd0);
      check("rm_state",   {30'd0, bus.arb_state}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      cnt_a = 0;
      cnt_b = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         cnt_a += int'(bus.dm_rvalid);
         cnt_b += int'(bus.busy);
      end
      check("rm_no_dm_rvalid", 32'(cnt_a), 32'd0);
      check("rm_no_busy",      32'(cnt_b), 32'd0);
      check("rm_state_idle",   {30'd0, bus.arb_state}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
